// File: rtl/arb_pkg.sv
// Shared definitions for the dff_bank_arbiter slice: FSM state encoding and
// the round-robin winner search used by the arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    // First set bit scanning upward from (last+1) mod num_req, wrapping.
    // Returns last unchanged when nothing is requested.
    function automatic int unsigned rr_next(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        last,
        input int unsigned        num_req
    );
        int unsigned idx;
        int unsigned result;
        result = last;
        // Scan from the far end down so the nearest candidate is assigned last.
        for (int unsigned k = MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = last + k;
                if (idx >= num_req) idx = idx - num_req;
                if (req[idx[MAX_IDX_W-1:0]]) result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared register bank: requests, write data,
// and the grant / acknowledge / owner / contents returned by the arbiter.
interface dff_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic [IDX_W-1:0]         owner;
    logic [WIDTH-1:0]         q;

    modport master (
        output req, wdata,
        input  gnt, ack, owner, q
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, owner, q
    );
endinterface

// File: rtl/dff_bank.sv
// WIDTH-bit register with load enable; asynchronous active-high reset to 0.
module dff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) q <= '0;
        else if (en)     q <= d;
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer in front of one shared dff_bank:
// IDLE picks a winner, GRANT commits its data, ACK pulses the done strobe.
module dff_bank_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               async_reset,
    dff_bank_arbiter_if.slave  bus
);

    state_t               state, state_d;
    logic [IDX_W-1:0]     owner_r, owner_d;
    logic [NUM_REQ-1:0]   gnt_r, gnt_d;
    logic [NUM_REQ-1:0]   ack_r, ack_d;
    logic [MAX_REQ-1:0]   req_ext;
    logic [IDX_W-1:0]     winner;
    logic                 wr_en;
    logic [WIDTH-1:0]     wr_data;

    assign req_ext = MAX_REQ'(bus.req);
    assign winner  = IDX_W'(rr_next(req_ext, 32'(owner_r), NUM_REQ));

    // The write commits only if the owner still holds its request at GRANT exit.
    assign wr_en   = (state == GRANT) && bus.req[owner_r];
    assign wr_data = bus.wdata[owner_r*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state   <= IDLE;
            owner_r <= IDX_W'(NUM_REQ - 1);
            gnt_r   <= '0;
            ack_r   <= '0;
        end else begin
            state   <= state_d;
            owner_r <= owner_d;
            gnt_r   <= gnt_d;
            ack_r   <= ack_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        owner_d = owner_r;
        gnt_d   = '0;
        ack_d   = '0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_d        = GRANT;
                    owner_d        = winner;
                    gnt_d[winner]  = 1'b1;
                end
            end
            GRANT: begin
                if (wr_en) begin
                    state_d        = ACK;
                    ack_d[owner_r] = 1'b1;
                end else begin
                    state_d        = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    dff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk         (clk),
        .async_reset (async_reset),
        .en          (wr_en),
        .d           (wr_data),
        .q           (bus.q)
    );

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.owner = owner_r;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: a transaction-level model predicts
// grants and writes, a negedge monitor pops and compares what the DUT shows.
module tb_dff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic async_reset = 1'b1;
    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    dff_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit             is_ack;
        int             idx;
        logic [W-1:0]   data;
    } exp_t;

    exp_t         sb[$];
    int           m_last = N - 1;   // last granted requester
    int           m_cur  = 0;       // requester of the transaction in flight
    int           m_left = 0;       // cycles remaining in the current transaction
    logic [W-1:0] m_q    = '0;

    always @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            m_last = N - 1;
            m_left = 0;
            m_q    = '0;
            sb.delete();
        end else if (m_left == 2) begin
            if (bus.req[m_cur]) begin
                m_q = bus.wdata[m_cur*W +: W];
                sb.push_back('{is_ack: 1'b1, idx: m_cur, data: m_q});
                m_left = 1;
            end else begin
                m_left = 0;
            end
        end else if (m_left == 1) begin
            m_left = 0;
        end else if (|bus.req) begin
            for (int k = 1; k <= N; k++) begin
                if (bus.req[(m_last + k) % N]) begin
                    m_cur = (m_last + k) % N;
                    break;
                end
            end
            m_last = m_cur;
            sb.push_back('{is_ack: 1'b0, idx: m_cur, data: '0});
            m_left = 2;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("gnt_ack_overlap", 32'(|bus.gnt && |bus.ack), 0);
        check("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
        check("ack_onehot", 32'($onehot0(bus.ack)), 1);
        check("q_value", 32'(bus.q), 32'(m_q));
        if (|bus.gnt) begin
            if (sb.size() == 0) check("unexpected_gnt", 32'(bus.gnt), 0);
            else begin
                e = sb.pop_front();
                check("gnt_kind", 32'(e.is_ack), 0);
                check("gnt_vec", 32'(bus.gnt), 32'(1 << e.idx));
                check("owner", 32'(bus.owner), 32'(e.idx));
            end
        end
        if (|bus.ack) begin
            if (sb.size() == 0) check("unexpected_ack", 32'(bus.ack), 0);
            else begin
                e = sb.pop_front();
                check("ack_kind", 32'(e.is_ack), 1);
                check("ack_vec", 32'(bus.ack), 32'(1 << e.idx));
                check("ack_data", 32'(bus.q), 32'(e.data));
            end
        end
    end

    // ---------------- requester agents ----------------
    bit sticky[N];
    bit rand_mode = 1'b0;
    int waitc[N];
    int cyc = 0;

    task automatic set_data(input int i, input logic [W-1:0] d);
        bus.wdata[i*W +: W] = d;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i]) begin
                check("wait_bound", 32'(waitc[i] <= 3 * N), 1);
                waitc[i] = 0;
            end else if (bus.req[i]) waitc[i]++;
            else waitc[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.ack[i] && !sticky[i]) bus.req[i] = 1'b0;
            if (rand_mode) begin
                if (bus.req[i] && bus.gnt[i] && $urandom_range(7) == 0)
                    bus.req[i] = 1'b0;
                else if (!bus.req[i] && !bus.ack[i] && $urandom_range(2) == 0) begin
                    set_data(i, W'($urandom));
                    bus.req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_gnt(input int i);
        bit ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.gnt[i]) begin ok = 1'b1; break; end
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_any_gnt(output logic [N-1:0] g, output int at);
        g  = '0;
        at = cyc;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (|bus.gnt) begin g = bus.gnt; at = cyc; return; end
        end
        check("any_gnt_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        logic [W-1:0] rr_data[N];
        int           at, prev;

        bus.req   = '0;
        bus.wdata = '0;
        for (int i = 0; i < N; i++) begin sticky[i] = 1'b0; waitc[i] = 0; end
        repeat (2) @(negedge clk);
        async_reset = 1'b0;

        // First write after reset, then asynchronous reset mid-cycle.
        set_data(0, 8'hA5);
        bus.req[0] = 1'b1;
        repeat (3) tick();
        check("first_write_q", 32'(bus.q), 32'h A5);
        @(posedge clk);
        #3 async_reset = 1'b1;
        #1;
        check("reset_q", 32'(bus.q), 0);
        check("reset_gnt", 32'(bus.gnt), 0);
        check("reset_ack", 32'(bus.ack), 0);
        @(negedge clk);
        async_reset = 1'b0;

        // Round-robin under full load: 0,1,2,3 then 0 again, 3 cycles apart.
        for (int i = 0; i < N; i++) begin
            rr_data[i] = W'($urandom);
            set_data(i, rr_data[i]);
        end
        bus.req = '1;
        prev = 0;
        for (int j = 0; j < 5; j++) begin
            wait_any_gnt(g, at);
            check("rr_order", 32'(g), 32'(1 << (j % N)));
            if (j > 0) check("rr_spacing", at - prev, 3);
            prev = at;
            if (j == 3) bus.req[0] = 1'b1;
        end
        repeat (3) tick();

        // Withdrawal during GRANT: no write, no ack, IDLE again one edge later.
        set_data(2, 8'h3C);
        bus.req[2] = 1'b1;
        wait_gnt(2);
        bus.req[2] = 1'b0;
        tick();
        check("withdraw_ack", 32'(bus.ack), 0);
        check("withdraw_q", 32'(bus.q), 32'(rr_data[0]));
        set_data(1, 8'h5A);
        bus.req[1] = 1'b1;
        tick();
        check("after_withdraw_gnt", 32'(bus.gnt), 32'b0010);
        repeat (3) tick();

        // Reset during GRANT of requester 1; afterwards index 0 scans first.
        set_data(1, 8'h77);
        bus.req[1] = 1'b1;
        wait_gnt(1);
        #2 async_reset = 1'b1;
        #1;
        check("midtx_reset_q", 32'(bus.q), 0);
        check("midtx_reset_gnt", 32'(bus.gnt), 0);
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        bus.req = 4'b0011;
        @(negedge clk);
        async_reset = 1'b0;
        tick();
        check("post_reset_gnt", 32'(bus.gnt), 32'b0001);
        repeat (6) tick();
        check("post_reset_q", 32'(bus.q), 32'h22);

        // Sticky requester 1 keeps req through ACK; pending 3 must win next.
        bus.req = '0;
        tick();
        sticky[1] = 1'b1;
        set_data(1, 8'hC3);
        bus.req[1] = 1'b1;
        wait_gnt(1);
        set_data(3, 8'h96);
        bus.req[3] = 1'b1;
        wait_any_gnt(g, at);
        check("sticky_next", 32'(g), 32'b1000);
        sticky[1] = 1'b0;
        wait_any_gnt(g, at);
        check("sticky_after", 32'(g), 32'b0010);
        repeat (3) tick();

        // Random fairness stress.
        rand_mode = 1'b1;
        repeat (2000) tick();
        rand_mode = 1'b0;
        bus.req = '0;
        repeat (8) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
